// File: rtl/jpeg_pkg.sv
// Shared widths, quantizer reciprocal table and zigzag address map for the JPEG quantizer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package jpeg_pkg;

  localparam int IN_W    = 12;
  localparam int OUT_W   = 11;
  localparam int RECIP_W = 17;
  localparam int PROD_W  = IN_W + RECIP_W;
  localparam int BLK_N   = 64;
  localparam int IDX_W   = 6;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // round(65536/Q) for the standard luminance table, raster order (u*8+v)
  localparam logic [RECIP_W-1:0] RECIP [BLK_N] = '{
    17'd4096, 17'd5958, 17'd6554, 17'd4096, 17'd2731, 17'd1638, 17'd1285, 17'd1074,
    17'd5461, 17'd5461, 17'd4681, 17'd3449, 17'd2521, 17'd1130, 17'd1092, 17'd1192,
    17'd4681, 17'd5041, 17'd4096, 17'd2731, 17'd1638, 17'd1150, 17'd950,  17'd1170,
    17'd4681, 17'd3855, 17'd2979, 17'd2260, 17'd1285, 17'd753,  17'd819,  17'd1057,
    17'd3641, 17'd2979, 17'd1771, 17'd1170, 17'd964,  17'd601,  17'd636,  17'd851,
    17'd2731, 17'd1872, 17'd1192, 17'd1024, 17'd809,  17'd630,  17'd580,  17'd712,
    17'd1337, 17'd1024, 17'd840,  17'd753,  17'd636,  17'd542,  17'd546,  17'd649,
    17'd910,  17'd712,  17'd690,  17'd669,  17'd585,  17'd655,  17'd636,  17'd662
  };

  // natural (raster) index -> zigzag position
  localparam logic [IDX_W-1:0] ZZ [BLK_N] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

endpackage

// File: rtl/jpeg_zz_buffer.sv
// Ping-pong 2x64 reorder buffer: written at zigzag addresses, read out sequentially 0..63.
// Latency: first word one cycle after the bank fills when idle; back-to-back banks hand over gaplessly.
// Backpressure: none; the reader always finishes a bank before the writer can fill the next one.
module jpeg_zz_buffer
  import jpeg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic             wr_last_i,
  input  logic [OUT_W-1:0] wr_dat_i,
  output logic             rd_vld_o,
  output logic [OUT_W-1:0] rd_dat_o,
  output logic             rd_start_o
);

  logic [OUT_W-1:0] mem_q [0:2*BLK_N-1];
  logic             wr_bank_q;
  logic [1:0]       full_q;
  logic [1:0]       set_vec;
  logic [1:0]       clr_vec;
  logic             rd_last;
  logic             next_ready;

  rd_state_e        state_q;
  logic             rd_bank_q;
  logic [IDX_W-1:0] rd_addr_q;
  logic             rd_vld_q;
  logic             rd_start_q;
  logic [OUT_W-1:0] rd_dat_q;

  // Bank fill/release events; the other bank counts as ready if it fills on this very edge
  always_comb begin
    set_vec = 2'b00;
    clr_vec = 2'b00;
    if (wr_en_i && wr_last_i) set_vec[wr_bank_q] = 1'b1;
    rd_last = (state_q == RD_READ) && (rd_addr_q == IDX_W'(BLK_N - 1));
    if (rd_last) clr_vec[rd_bank_q] = 1'b1;
    next_ready = full_q[~rd_bank_q] | set_vec[~rd_bank_q];
  end

  // Reorder RAM write port; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[{wr_bank_q, wr_addr_i}] <= wr_dat_i;
  end

  // Write bank flips once the last coefficient of a block lands
  always_ff @(posedge clk_i) begin
    if (rst_i)                      wr_bank_q <= 1'b0;
    else if (wr_en_i && wr_last_i) wr_bank_q <= ~wr_bank_q;
  end

  // Full flags: set by the writer on block completion, cleared by the reader on its last word
  always_ff @(posedge clk_i) begin
    if (rst_i) full_q <= 2'b00;
    else       full_q <= (full_q & ~clr_vec) | set_vec;
  end

  // Read FSM with registered outputs; banks are consumed in the same alternating order they fill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_start_q <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      rd_vld_q   <= 1'b0;
      rd_start_q <= 1'b0;
      case (state_q)
        RD_IDLE: begin
          if (full_q[rd_bank_q]) begin
            rd_vld_q   <= 1'b1;
            rd_start_q <= 1'b1;
            rd_dat_q   <= mem_q[{rd_bank_q, IDX_W'(0)}];
            rd_addr_q  <= IDX_W'(1);
            state_q    <= RD_READ;
          end
        end
        RD_READ: begin
          rd_vld_q   <= 1'b1;
          rd_start_q <= (rd_addr_q == '0);
          rd_dat_q   <= mem_q[{rd_bank_q, rd_addr_q}];
          rd_addr_q  <= rd_addr_q + IDX_W'(1);
          if (rd_last) begin
            rd_bank_q <= ~rd_bank_q;
            if (!next_ready) state_q <= RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  assign rd_vld_o   = rd_vld_q;
  assign rd_dat_o   = rd_dat_q;
  assign rd_start_o = rd_start_q;

endmodule

// File: rtl/jpeg_quant_zigzag.sv
// JPEG quantizer: reciprocal multiply, round half up, saturate, then zigzag reorder via ping-pong buffer.
// Latency: first output on the 3rd edge after the 64th coefficient of a block is accepted (reader idle).
// Backpressure: none; one coefficient per cycle accepted while en_in_i is high, output is free-running.
module jpeg_quant_zigzag
  import jpeg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_in_i,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             en_out_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_block_start_o
);

  localparam logic signed [PROD_W-1:0] RND   = PROD_W'(32768);
  localparam logic signed [PROD_W-1:0] Q_MAX = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Q_MIN = ~Q_MAX;

  logic [IDX_W-1:0]         cnt_q;
  logic [IDX_W-1:0]         cnt_d;
  logic signed [PROD_W-1:0] in_ext;
  logic signed [PROD_W-1:0] recip_ext;
  logic signed [PROD_W-1:0] p_d;
  logic signed [PROD_W-1:0] p_q;
  logic                     vld1_q;
  logic [IDX_W-1:0]         idx1_q;
  logic signed [PROD_W-1:0] sum;
  logic signed [PROD_W-1:0] sh;
  logic [OUT_W-1:0]         q_d;
  logic [OUT_W-1:0]         q_q;
  logic                     vld2_q;
  logic                     last2_q;
  logic [IDX_W-1:0]         zz2_q;

  // Raster index counter and stage-1 product; both operands widened so the product is full width
  always_comb begin
    cnt_d     = en_in_i ? cnt_q + IDX_W'(1) : cnt_q;
    in_ext    = {{(PROD_W - IN_W){in_data_i[IN_W-1]}}, in_data_i};
    recip_ext = {{(PROD_W - RECIP_W){1'b0}}, RECIP[cnt_q]};
    p_d       = in_ext * recip_ext;
  end

  // Stage-2 rounding (add half, arithmetic shift) and clamp to the output range
  always_comb begin
    sum = p_q + RND;
    sh  = sum >>> 16;
    if (sh > Q_MAX)      q_d = Q_MAX[OUT_W-1:0];
    else if (sh < Q_MIN) q_d = Q_MIN[OUT_W-1:0];
    else                 q_d = sh[OUT_W-1:0];
  end

  // Control state: input counter and pipeline valids
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      vld1_q <= en_in_i;
      vld2_q <= vld1_q;
    end
  end

  // Datapath registers; qualified by the valids so they need no reset
  always_ff @(posedge clk_i) begin
    p_q     <= p_d;
    idx1_q  <= cnt_q;
    q_q     <= q_d;
    zz2_q   <= ZZ[idx1_q];
    last2_q <= (idx1_q == IDX_W'(BLK_N - 1));
  end

  jpeg_zz_buffer u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (vld2_q),
    .wr_addr_i  (zz2_q),
    .wr_last_i  (last2_q),
    .wr_dat_i   (q_q),
    .rd_vld_o   (en_out_o),
    .rd_dat_o   (out_data_o),
    .rd_start_o (out_block_start_o)
  );

endmodule

// File: tb/tb_jpeg_quant_zigzag.sv
// Directed bench for jpeg_quant_zigzag: hand-computed vectors plus a reference quantizer model.
module tb_jpeg_quant_zigzag;

  logic               clk = 1'b0;
  logic               rst;
  logic               en_in;
  logic [11:0]        in_data;
  logic               en_out;
  logic signed [10:0] out_data;
  logic               sob;

  always #5 clk = ~clk;

  jpeg_quant_zigzag dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .en_in_i           (en_in),
    .in_data_i         (in_data),
    .en_out_o          (en_out),
    .out_data_o        (out_data),
    .out_block_start_o (sob)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int od[$];
  int os[$];
  int oc[$];
  int expq[$];
  int blk[64];
  int vv[64];
  int acc;
  int nz;
  int bad_ord;

  int QT[64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  // zigzag position -> natural index
  int ZZO[64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (en_out === 1'b1) begin
      od.push_back(int'(out_data));
      os.push_back(int'(sob));
      oc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int x, input int nat);
    longint r;
    longint p;
    r = (65536 + QT[nat] / 2) / QT[nat];
    p = (longint'(x) * r + 32768) >>> 16;
    if (p > 1023)  p = 1023;
    if (p < -1024) p = -1024;
    return int'(p);
  endfunction

  task automatic drive_block(input int gap_pct);
    for (int k = 0; k < 64; k++) expq.push_back(ref_q(blk[ZZO[k]], ZZO[k]));
    for (int i = 0; i < 64; i++) begin
      while (int'($urandom_range(99, 0)) < gap_pct) begin
        @(negedge clk);
        en_in = 1'b0;
      end
      @(negedge clk);
      en_in   = 1'b1;
      in_data = 12'(blk[i]);
    end
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(4095, 0)) - 2048;
  endtask

  task automatic wait_outs(input string tag, input int n);
    int t = 0;
    while (od.size() < n && t < 3000) begin
      @(posedge clk);
      #2;
      t++;
    end
    repeat (8) @(posedge clk);
    #2;
    chk(tag, od.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    n = (od.size() < expq.size()) ? od.size() : expq.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_dat%0d", tag, k), od[k], expq[k]);
      chk($sformatf("%s_sob%0d", tag, k), os[k], (k % 64 == 0) ? 1 : 0);
    end
    od.delete();
    os.delete();
    oc.delete();
    expq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en_in = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en_out", int'(en_out), 0);
    chk("rst_sob", int'(sob), 0);
    chk("rst_dat", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // DC impulse: 1024/16 rounds to 64, everything else zero, latency 3
    blk = '{default: 0};
    blk[0] = 1024;
    drive_block(0);
    @(posedge clk);
    #2;
    acc = cyc;
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t1_cnt", 64);
    if (od.size() >= 64) begin
      chk("t1_latency", oc[0] - acc, 3);
      chk("t1_dc", od[0], 64);
      chk("t1_sob0", os[0], 1);
      nz = 0;
      for (int k = 1; k < 64; k++) if (od[k] != 0) nz++;
      chk("t1_ac_zero", nz, 0);
    end
    compare_stream("t1");

    // Raster ramp: value v*Q[i] quantizes back to v, read out in zigzag order
    for (int i = 0; i < 64; i++) begin
      vv[i]  = (i * QT[i] <= 2047) ? i : 2047 / QT[i];
      blk[i] = vv[i] * QT[i];
    end
    drive_block(0);
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t2_cnt", 64);
    for (int k = 0; k < 64; k++)
      if (k < od.size()) chk($sformatf("t2_nat%0d", k), od[k], vv[ZZO[k]]);
    compare_stream("t2");

    // Rounding and sign corners, three blocks back to back
    blk = '{default: 0};
    blk[0] = -8; blk[1] = -6; blk[2] = 2047; blk[63] = -2048;
    drive_block(0);
    blk = '{default: 0};
    blk[0] = 8;
    drive_block(0);
    blk = '{default: 0};
    blk[0] = -2048;
    drive_block(0);
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t3_cnt", 192);
    if (od.size() >= 192) begin
      chk("t3_neg8", od[0], 0);
      chk("t3_neg6", od[1], -1);
      chk("t3_pos2047", od[5], 205);
      chk("t3_neg2048_q99", od[63], -21);
      chk("t3_pos8", od[64], 1);
      chk("t3_neg2048_q16", od[128], -128);
    end
    compare_stream("t3");

    // Three random blocks, continuous: 192 gapless outputs
    for (int b = 0; b < 3; b++) begin
      rand_blk();
      drive_block(0);
    end
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t4_cnt", 192);
    if (oc.size() >= 192) begin
      chk("t4_gapless", oc[191] - oc[0], 191);
      bad_ord = 0;
      for (int k = 1; k < 192; k++) if (oc[k] != oc[k-1] + 1) bad_ord++;
      chk("t4_holes", bad_ord, 0);
    end
    compare_stream("t4");

    // Ten random blocks with ~50% input gaps
    for (int b = 0; b < 10; b++) begin
      rand_blk();
      drive_block(50);
    end
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t5_cnt", 640);
    compare_stream("t5");

    // Reset at input 30 of block 2 while block 1 is being read
    rand_blk();
    drive_block(0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      en_in   = 1'b1;
      in_data = 12'($urandom_range(4095, 0));
    end
    @(negedge clk);
    en_in = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_rst_en_out", int'(en_out), 0);
    chk("t6_rst_sob", int'(sob), 0);
    chk("t6_pre_cnt", od.size(), 28);
    compare_stream("t6_pre");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("t6_flushed", od.size(), 0);
    rand_blk();
    drive_block(0);
    @(negedge clk);
    en_in = 1'b0;
    wait_outs("t6_cnt", 64);
    compare_stream("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jpeg_quant_zigzag.md
JPEG_QUANT_ZIGZAG -- requirements
Module: jpeg_quant_zigzag

Interface
REQ-001 IN_W, 12, signed DCT coefficient width; SHALL match the DCT stage output width.
REQ-002 OUT_W, 11, signed quantized coefficient width; SHALL be used for saturation bounds.
REQ-003 RECIP_W, 17, unsigned reciprocal width; reciprocal = round(65536/Q).
REQ-004 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 En_In  input  1  coefficient valid; one coefficient is accepted per cycle while high.
REQ-007 In_Data  input  IN_W  signed DCT coefficient, block raster order (index = u*8+v, 64 per block).
REQ-008 En_Out  output  1  quantized coefficient valid.
REQ-009 Out_Data  output  OUT_W  signed quantized coefficient, zigzag order.
REQ-010 Out_Block_Start  output  1  high together with En_Out on zigzag position 0 of each block.

Function
REQ-011 An input counter (0..63) SHALL increment on each accepted coefficient, wrap 63->0, and hold while En_In is low; gaps inside a block SHALL be tolerated.
REQ-012 Stage 1 SHALL compute p = In_Data * RECIP[idx] as a signed product of IN_W+RECIP_W bits.
REQ-013 Stage 2 SHALL compute q = (p + 32768) >>> 16 (round half up), saturated to [-1024, 1023].
REQ-014 q SHALL be written into the active write bank of a 2x64 ping-pong buffer at address ZZ[idx] (natural-to-zigzag map).
REQ-015 When the 64th coefficient of a block is written, that bank SHALL be marked full and writes SHALL switch to the other bank.
REQ-016 Read FSM states: IDLE, READ. IDLE->READ when a bank is full; READ outputs addresses 0..63 on consecutive cycles, with no gaps. At 63 it releases the bank, then enters READ on the other bank if that bank is full, else IDLE.
REQ-017 En_Out SHALL first assert on the 3rd rising edge after the edge that accepts the 64th coefficient, when the reader was IDLE.
REQ-018 Sustained En_In=1 at one coefficient per cycle SHALL produce continuous En_Out with no loss. Overflow cannot occur, because a read (64 cycles) always completes before the next write bank fills.
REQ-019 A simultaneous last write to bank A and last read from bank B SHALL hand over with no idle cycle and no data corruption.
REQ-020 No backpressure exists. Out_Data SHALL hold its last value while En_Out is low.

Reset
REQ-021 On Reset: En_Out=0, Out_Block_Start=0, Out_Data=0, input counter=0, write bank=0, both full flags=0, FSM=IDLE, pipeline valids=0.
REQ-022 Reset mid-block or mid-read SHALL discard all partial and pending blocks. The first En_In after reset SHALL be treated as index 0.
REQ-023 Buffer RAM contents need no reset.

Structure
REQ-024 Shared package jpeg_pkg SHALL hold IN_W/OUT_W/RECIP_W, the 64-entry RECIP table (standard JPEG luminance Q table, e.g. Q[0]=16->4096, Q[1]=11->5958), and the 64-entry ZZ table.
REQ-025 One sub-module, jpeg_zz_buffer, SHALL implement the 2x64 ping-pong RAM, full flags and read FSM. The quantizer pipeline stays in the top module.

Verification
REQ-026 Block with In_Data[0]=1024, all others 0, continuous En_In -> Out_Data 64 at zigzag position 0 with Out_Block_Start=1, then 63 zeros; En_Out rises 3 cycles after the 64th input.
REQ-027 Raster-order inputs with In_Data[i]=i*Q[i] (IN_W-range-safe) -> output sequence equals natural index in zigzag order: 0,1,8,16,9,2,...,63.
REQ-028 In_Data[0]=-8 (Q=16) -> 0; In_Data[0]=8 -> 1; In_Data[0]=-2048 -> -128; rounding and sign verified against the package table.
REQ-029 Three back-to-back blocks with continuous En_In -> 192 consecutive En_Out cycles, Out_Block_Start at outputs 0, 64 and 128, and no drops.
REQ-030 Random En_In gaps (50% duty) over 10 blocks -> output stream equals the reference model, block by block.
REQ-031 Reset asserted at input 30 of block 2 while block 1 is reading -> En_Out=0 on the next edge; the following clean block is output correctly from index 0.
